fetch_queue: RTL and testbench

//  Instruction prefetch stage. Owns the fetch PC and drives the async instruction memory.

---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_queue_if.sv | 40 ++++
 rtl/fq_storage.sv | 26 ++
 rtl/fetch_queue.sv | 100 ++++++++++
 tb/tb_fetch_queue.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package fetch_pkg;

    localparam int unsigned INSTR_BYTES      = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc_plus4;
        logic [31:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch queue bus: instruction-memory port, decode redirect and IF_ID valid/ready output.
interface fetch_queue_if;

    logic [31:0] IMem_Addr;
    logic [31:0] IMem_Instr;
    logic        Redirect;
    logic [31:0] Redirect_PC;
    logic        Out_Valid;
    logic        Out_Ready;
    logic [31:0] Out_Instr;
    logic [31:0] Out_PCPlus4;
    logic        Full;

    // Fetch queue side
    modport master (
        output IMem_Addr,
        input  IMem_Instr,
        input  Redirect,
        input  Redirect_PC,
        output Out_Valid,
        input  Out_Ready,
        output Out_Instr,
        output Out_PCPlus4,
        output Full
    );

    // Memory / decode / hazard-unit side
    modport slave (
        input  IMem_Addr,
        output IMem_Instr,
        output Redirect,
        output Redirect_PC,
        input  Out_Valid,
        output Out_Ready,
        input  Out_Instr,
        input  Out_PCPlus4,
        input  Full
    );

endinterface

// File: rtl/fq_storage.sv
// Fetch queue entry array: one synchronous write port, one asynchronous read port, no reset.
module fq_storage
    import fetch_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          Clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  fq_entry_t     wdata,
    input  logic [AW-1:0] raddr,
    output fq_entry_t     rdata
);

    fq_entry_t mem [DEPTH];

    always_ff @(posedge Clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch stage: owns the fetch PC and buffers {PC+4, instr} pairs for IF_ID.
// Optional zero-latency empty-queue bypass: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic          Clk,
    input  logic          Rst,
    fetch_queue_if.master bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [31:0]      fetch_pc;

    logic      empty_c;
    logic      full_c;
    logic      byp_c;
    logic      valid_c;
    logic      deq_c;
    logic      enq_c;
    logic      push_c;
    logic      pop_c;
    fq_entry_t head_c;
    fq_entry_t wdata_c;

    // Handshake decode; redirect blocks enqueue, a bypassed-and-consumed fetch is never stored
    always_comb begin
        empty_c = (count == '0);
        full_c  = (count == CNT_W'(DEPTH));
`ifdef FETCH_QUEUE_BYPASS_EN
        byp_c   = empty_c & ~bus.Redirect;
`else
        byp_c   = 1'b0;
`endif
        valid_c = ~empty_c | byp_c;
        deq_c   = valid_c & bus.Out_Ready;
        enq_c   = ~bus.Redirect & (~full_c | deq_c);
        push_c  = enq_c & ~(byp_c & deq_c);
        pop_c   = deq_c & ~empty_c;
        wdata_c = '{pc_plus4: fetch_pc + 32'(INSTR_BYTES), instr: bus.IMem_Instr};
    end

    fq_storage #(.DEPTH(DEPTH)) u_storage (
        .Clk   (Clk),
        .we    (push_c),
        .waddr (wr_ptr),
        .wdata (wdata_c),
        .raddr (rd_ptr),
        .rdata (head_c)
    );

    // Pointer, occupancy and fetch PC state
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            fetch_pc <= RESET_PC;
        end else if (bus.Redirect) begin
            rd_ptr   <= wr_ptr;
            count    <= '0;
            fetch_pc <= bus.Redirect_PC;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push_c) - CNT_W'(pop_c);
            if (enq_c) begin
                fetch_pc <= fetch_pc + 32'(INSTR_BYTES);
            end
        end
    end

    // Head presentation; zeros while empty so stale array contents never leak out
    always_comb begin
        bus.IMem_Addr   = fetch_pc;
        bus.Out_Valid   = valid_c;
        bus.Full        = full_c;
        bus.Out_Instr   = '0;
        bus.Out_PCPlus4 = '0;
        if (byp_c) begin
            bus.Out_Instr   = bus.IMem_Instr;
            bus.Out_PCPlus4 = wdata_c.pc_plus4;
        end else if (!empty_c) begin
            bus.Out_Instr   = head_c.instr;
            bus.Out_PCPlus4 = head_c.pc_plus4;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;
    import fetch_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] IMEM_KEY = 32'hA5A5_0000;

    typedef struct {
        logic [31:0] pcp4;
        logic [31:0] instr;
    } ent_t;

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    ent_t        mq[$];
    logic [31:0] mpc = 32'h0;

    always #5 Clk = ~Clk;

    fetch_queue_if bus();
    assign bus.IMem_Instr = bus.IMem_Addr ^ IMEM_KEY;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic byp_now(input logic r);
`ifdef FETCH_QUEUE_BYPASS_EN
        return (mq.size() == 0) && !r;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_model(input string tag);
        logic        b;
        logic        ev;
        logic [31:0] ei;
        logic [31:0] ep;
        b  = byp_now(bus.Redirect);
        ev = (mq.size() != 0) || b;
        ei = 32'h0;
        ep = 32'h0;
        if (b) begin
            ei = mpc ^ IMEM_KEY;
            ep = mpc + 32'd4;
        end else if (mq.size() != 0) begin
            ei = mq[0].instr;
            ep = mq[0].pcp4;
        end
        chk({tag, ".addr"},  bus.IMem_Addr,          mpc);
        chk({tag, ".valid"}, {31'b0, bus.Out_Valid}, {31'b0, ev});
        chk({tag, ".instr"}, bus.Out_Instr,          ei);
        chk({tag, ".pcp4"},  bus.Out_PCPlus4,        ep);
        chk({tag, ".full"},  {31'b0, bus.Full},      {31'b0, mq.size() == DEPTH});
    endtask

    task automatic model_step(input logic r, input logic [31:0] rpc, input logic rdy);
        logic b;
        logic deq;
        logic enq;
        b   = byp_now(r);
        deq = ((mq.size() != 0) || b) && rdy;
        enq = !r && ((mq.size() < DEPTH) || deq);
        if (r) begin
            mq.delete();
            mpc = rpc;
        end else begin
            if (deq && !b) void'(mq.pop_front());
            if (enq) begin
                if (!(b && deq)) mq.push_back('{mpc + 32'd4, mpc ^ IMEM_KEY});
                mpc = mpc + 32'd4;
            end
        end
    endtask

    // Drive at negedge, compare just after, advance the model across the posedge
    task automatic cycle(input string tag, input logic r, input logic [31:0] rpc, input logic rdy);
        bus.Redirect    = r;
        bus.Redirect_PC = rpc;
        bus.Out_Ready   = rdy;
        #1;
        check_model(tag);
        model_step(r, rpc, rdy);
        @(negedge Clk);
    endtask

    initial begin
        bus.Redirect    = 1'b0;
        bus.Redirect_PC = 32'h0;
        bus.Out_Ready   = 1'b0;
        @(negedge Clk);
        #1;
        chk("rst.valid", {31'b0, bus.Out_Valid}, 32'h0);
        chk("rst.addr",  bus.IMem_Addr, 32'h0);
        chk("rst.full",  {31'b0, bus.Full}, 32'h0);
        chk("rst.instr", bus.Out_Instr, 32'h0);
        @(negedge Clk);
        Rst = 1'b1;

        // Fill with consumer stalled
        for (int i = 0; i < 6; i++) cycle("fill", 1'b0, 32'h0, 1'b0);
        chk("fill.full",  {31'b0, bus.Full}, 32'h1);
        chk("fill.addr",  bus.IMem_Addr, 32'h10);
        chk("fill.instr", bus.Out_Instr, 32'hA5A5_0000);
        chk("fill.pcp4",  bus.Out_PCPlus4, 32'h4);

        // Streaming drain while full
        for (int i = 0; i < 5; i++) begin
            bus.Out_Ready = 1'b1;
            #1;
            chk("drain.pcp4", bus.Out_PCPlus4, 32'h4 + 32'(i) * 32'h4);
            chk("drain.full", {31'b0, bus.Full}, 32'h1);
            cycle("drain", 1'b0, 32'h0, 1'b1);
        end

        // Redirect on a full queue
        for (int i = 0; i < 2; i++) cycle("refill", 1'b0, 32'h0, 1'b0);
        cycle("redir", 1'b1, 32'h100, 1'b0);
`ifndef FETCH_QUEUE_BYPASS_EN
        chk("redir.valid", {31'b0, bus.Out_Valid}, 32'h0);
`endif
        chk("redir.addr", bus.IMem_Addr, 32'h100);
        cycle("redir1", 1'b0, 32'h0, 1'b0);
        chk("redir.pcp4", bus.Out_PCPlus4, 32'h104);

        // Redirect with simultaneous dequeue
        for (int i = 0; i < 3; i++) cycle("pre4", 1'b0, 32'h0, 1'b0);
        cycle("redir_deq", 1'b1, 32'h200, 1'b1);
        for (int i = 0; i < 4; i++) cycle("post4", 1'b0, 32'h0, 1'b1);

        // Async reset between edges
        #2;
        Rst = 1'b0;
        #1;
        chk("arst.valid", {31'b0, bus.Out_Valid}, 32'h0);
        chk("arst.addr",  bus.IMem_Addr, 32'h0);
        mq.delete();
        mpc = 32'h0;
        @(negedge Clk);
        Rst = 1'b1;
        for (int i = 0; i < 3; i++) cycle("refill0", 1'b0, 32'h0, 1'b0);
        chk("refill0.pcp4", bus.Out_PCPlus4, 32'h4);

        // Empty queue, consumer ready (bypass path when enabled)
        cycle("empty_r", 1'b1, 32'h300, 1'b1);
        for (int i = 0; i < 4; i++) cycle("empty_rdy", 1'b0, 32'h0, 1'b1);

        // Redirect across 32-bit PC wrap
        cycle("wrap_r", 1'b1, 32'hFFFF_FFF8, 1'b0);
        for (int i = 0; i < 5; i++) cycle("wrap", 1'b0, 32'h0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic r;
            logic rdy;
            r   = ($urandom_range(0, 11) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            cycle("rand", r, $urandom & 32'hFFFF_FFFC, rdy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
